// File: rtl/mat_mul_pkg.sv
// Shared defaults and FSM state encoding for the matrix-multiply sequencer.
// Pure declarations: no latency, no backpressure.
package mat_mul_pkg;

    localparam int N_DEFAULT  = 8;
    localparam int IW_DEFAULT = $clog2(N_DEFAULT);
    localparam int AW_DEFAULT = 2 * IW_DEFAULT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mm_idx_counter.sv
// Nested i/j/k iteration counters (k innermost); advance one step per cycle with en.
// Flags are combinational views of the current count; en low simply holds the count.
module mm_idx_counter
    import mat_mul_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [IW-1:0] k,
    output logic          last,
    output logic          k_first,
    output logic          k_last
);

    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

    logic j_last;
    logic i_last;

    assign k_first = (k == '0);
    assign k_last  = (k == IDX_MAX);
    assign j_last  = (j == IDX_MAX);
    assign i_last  = (i == IDX_MAX);
    assign last    = i_last && j_last && k_last;

    // N is a power of two, so the natural binary wrap gives N-1 -> 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (en) begin
            k <= k + IW'(1);
            if (k_last) begin
                j <= j + IW'(1);
                if (j_last) begin
                    i <= i + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mat_mul_seq_ctrl.sv
// Matrix-multiply sequencer: one A/B read per cycle, MAC strobes +1 cycle, C write +2 cycles.
// stall holds the issue counters and inserts a bubble; in-flight stages keep draining.
module mat_mul_seq_ctrl
    import mat_mul_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = $clog2(N),
    parameter int AW = 2 * IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic          busy,
    output logic          done
);

    state_t state;
    state_t state_nxt;

    logic          issue;
    logic [IW-1:0] cnt_i;
    logic [IW-1:0] cnt_j;
    logic [IW-1:0] cnt_k;
    logic          cnt_last;
    logic          cnt_k_first;
    logic          cnt_k_last;

    logic          k_first_s0;
    logic          k_last_s0;
    logic [AW-1:0] c_addr_s0;
    logic          wr_s1;
    logic [AW-1:0] c_addr_s1;

    mm_idx_counter #(
        .N  (N),
        .IW (IW)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .en      (issue),
        .i       (cnt_i),
        .j       (cnt_j),
        .k       (cnt_k),
        .last    (cnt_last),
        .k_first (cnt_k_first),
        .k_last  (cnt_k_last)
    );

    // The start edge itself issues the first read, so issue 0 lands on E0.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    issue     = !stall;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = !stall;
                if (issue && cnt_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // rd_en and mac_en are the only pipeline valids that can still
                // create work; the final c_we retires on the DONE edge.
                if (!rd_en && !mac_en) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_en      <= 1'b0;
            a_addr     <= '0;
            b_addr     <= '0;
            k_first_s0 <= 1'b0;
            k_last_s0  <= 1'b0;
            c_addr_s0  <= '0;
            mac_en     <= 1'b0;
            mac_clr    <= 1'b0;
            wr_s1      <= 1'b0;
            c_addr_s1  <= '0;
            c_we       <= 1'b0;
            c_addr     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_en <= issue;
            if (issue) begin
                a_addr     <= {cnt_i, cnt_k};
                b_addr     <= {cnt_k, cnt_j};
                c_addr_s0  <= {cnt_i, cnt_j};
                k_first_s0 <= cnt_k_first;
                k_last_s0  <= cnt_k_last;
            end

            mac_en    <= rd_en;
            mac_clr   <= rd_en && k_first_s0;
            wr_s1     <= rd_en && k_last_s0;
            c_addr_s1 <= c_addr_s0;

            c_we   <= wr_s1;
            c_addr <= c_addr_s1;

            busy <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_mat_mul_seq_ctrl.sv
// Bench for mat_mul_seq_ctrl: reference issue/MAC/write schedule from plain loop arithmetic,
// scoreboard queues popped by a negedge monitor, plus a memory+MAC model checking C = I*B = B.
module tb_mat_mul_seq_ctrl;

    localparam int N   = 8;
    localparam int IW  = 3;
    localparam int AW  = 6;
    localparam int NN  = N * N;
    localparam int NNN = N * N * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic          busy;
    logic          done;

    mat_mul_seq_ctrl #(.N(N), .IW(IW), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stall   (stall),
        .rd_en   (rd_en),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .mac_en  (mac_en),
        .mac_clr (mac_clr),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int v1;
        int v2;
    } exp_t;

    exp_t q_rd[$];
    exp_t q_mac[$];
    exp_t q_we[$];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference schedule: issue n carries (i,j,k) = (n/N^2, (n/N)%N, n%N).
    bit m_active   = 1'b0;
    bit m_busy     = 1'b0;
    bit m_exp_done = 1'b0;
    int m_n        = 0;
    int m_done_cyc = -1;
    int m_free_at  = 0;
    int m_start_cyc = 0;
    int m_rst_cyc  = -1;

    always @(posedge clk) begin : model
        int mi, mj, mk;
        cyc = cyc + 1;
        if (!rst) begin
            q_rd.delete();
            q_mac.delete();
            q_we.delete();
            m_active   = 1'b0;
            m_busy     = 1'b0;
            m_exp_done = 1'b0;
            m_done_cyc = -1;
            m_free_at  = cyc + 1;
            m_rst_cyc  = cyc;
        end else begin
            if (!m_active && cyc >= m_free_at && start) begin
                m_active    = 1'b1;
                m_busy      = 1'b1;
                m_n         = 0;
                m_free_at   = 32'h7fff_ffff;
                m_start_cyc = cyc;
            end
            if (m_active && !stall) begin
                mk = m_n % N;
                mj = (m_n / N) % N;
                mi = m_n / NN;
                q_rd.push_back(exp_t'{cyc, mi * N + mk, mk * N + mj});
                q_mac.push_back(exp_t'{cyc + 1, int'(mk == 0), 0});
                if (mk == N - 1) q_we.push_back(exp_t'{cyc + 2, mi * N + mj, 0});
                m_n++;
                if (m_n == NNN) begin
                    m_active   = 1'b0;
                    m_done_cyc = cyc + 3;
                    m_free_at  = cyc + 5;
                end
            end
            m_exp_done = (cyc == m_done_cyc);
            if (m_exp_done) m_busy = 1'b0;
        end
    end

    // Behavioural memories (read latency 1) and MAC; also tallies observed strobes.
    int unsigned mem_a[NN];
    int unsigned mem_b[NN];
    int unsigned mem_c[NN];
    int unsigned a_q, b_q, acc;
    int cnt_rd = 0, cnt_mac = 0, cnt_clr = 0, cnt_we = 0, cnt_done = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            a_q <= mem_a[a_addr];
            b_q <= mem_b[b_addr];
        end
        if (mac_en) acc <= mac_clr ? a_q * b_q : acc + a_q * b_q;
        if (c_we) mem_c[c_addr] <= acc;
        cnt_rd   <= cnt_rd + int'(rd_en);
        cnt_mac  <= cnt_mac + int'(mac_en);
        cnt_clr  <= cnt_clr + int'(mac_clr);
        cnt_we   <= cnt_we + int'(c_we);
        cnt_done <= cnt_done + int'(done);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        chk("busy", busy, m_busy);
        chk("done", done, m_exp_done);
        chk("busy_done_exclusive", busy & done, 0);
        if (cyc == m_rst_cyc)
            chk("reset_outputs", {rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr, busy, done}, 0);
        if (mac_clr) chk("mac_clr_without_mac_en", mac_en, 1);

        while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin
            chk("rd_issue_missed_cycle", cyc, q_rd[0].cyc);
            void'(q_rd.pop_front());
        end
        if (rd_en) begin
            if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
                e = q_rd.pop_front();
                chk("a_addr", a_addr, e.v1);
                chk("b_addr", b_addr, e.v2);
            end else chk("rd_en_unexpected", rd_en, 0);
        end

        while (q_mac.size() > 0 && q_mac[0].cyc < cyc) begin
            chk("mac_en_missed_cycle", cyc, q_mac[0].cyc);
            void'(q_mac.pop_front());
        end
        if (mac_en) begin
            if (q_mac.size() > 0 && q_mac[0].cyc == cyc) begin
                e = q_mac.pop_front();
                chk("mac_clr", mac_clr, e.v1);
            end else chk("mac_en_unexpected", mac_en, 0);
        end

        while (q_we.size() > 0 && q_we[0].cyc < cyc) begin
            chk("c_we_missed_cycle", cyc, q_we[0].cyc);
            void'(q_we.pop_front());
        end
        if (c_we) begin
            if (q_we.size() > 0 && q_we[0].cyc == cyc) begin
                e = q_we.pop_front();
                chk("c_addr", c_addr, e.v1);
            end else chk("c_we_unexpected", c_we, 0);
        end
    end

    task automatic wait_done(input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1);
    endtask

    task automatic check_c_equals_b(input string nm);
        for (int x = 0; x < NN; x++) chk(nm, mem_c[x], mem_b[x]);
    endtask

    initial begin
        int b_rd, b_mac, b_clr, b_we, b_done;
        bit ok;

        for (int x = 0; x < NN; x++) begin
            mem_a[x] = ((x / N) == (x % N)) ? 1 : 0;
            mem_b[x] = $urandom_range(0, 255);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single start pulse, no stalls.
        b_rd = cnt_rd; b_mac = cnt_mac; b_clr = cnt_clr; b_we = cnt_we;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, "p1_done_seen");
        chk("p1_done_latency", cyc - m_start_cyc, NNN + 2);
        repeat (5) @(negedge clk);
        chk("p1_rd_count", cnt_rd - b_rd, NNN);
        chk("p1_mac_count", cnt_mac - b_mac, NNN);
        chk("p1_clr_count", cnt_clr - b_clr, NN);
        chk("p1_we_count", cnt_we - b_we, NN);
        check_c_equals_b("p1_c_equals_b");

        // Five-cycle stall landing on k=4 of dot product (1,2).
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (83) @(negedge clk);
        stall = 1'b1;
        repeat (5) @(negedge clk);
        stall = 1'b0;
        wait_done(2000, "p2_done_seen");
        chk("p2_done_latency", cyc - m_start_cyc, NNN + 2 + 5);
        repeat (5) @(negedge clk);

        // start held through the whole run, including the DONE cycle.
        b_rd = cnt_rd; b_done = cnt_done;
        start = 1'b1;
        wait_done(2000, "p3_done_seen");
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("p3_single_run_rd_count", cnt_rd - b_rd, NNN);
        chk("p3_single_done", cnt_done - b_done, 1);

        // Reset mid-run: nothing may follow it.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (199) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        b_we = cnt_we; b_done = cnt_done; b_rd = cnt_rd;
        repeat (30) @(negedge clk);
        chk("p4_no_c_we_after_reset", cnt_we - b_we, 0);
        chk("p4_no_done_after_reset", cnt_done - b_done, 0);
        chk("p4_no_rd_after_reset", cnt_rd - b_rd, 0);

        // Random stalls with fresh B.
        for (int x = 0; x < NN; x++) mem_b[x] = $urandom_range(0, 255);
        start = 1'b1;
        stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("p5_done_seen", ok, 1);
        stall = 1'b0;
        repeat (5) @(negedge clk);
        check_c_equals_b("p5_c_equals_b");

        chk("q_rd_drained", q_rd.size(), 0);
        chk("q_mac_drained", q_mac.size(), 0);
        chk("q_we_drained", q_we.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_mul_seq_ctrl.md
# mat_mul_seq_ctrl

Sequencer for the N×N matrix-multiply datapath. It walks the (i, j, k) iteration space, issuing one A/B read-address pair per cycle. It drives the external multiply-accumulate (MAC) unit's enable and clear strobes, and emits one C write per dot product. It sits between the host start/done handshake and the operand memories, the MAC, and the result memory.

## Interface
Parameters:
- `N`, 8: matrix dimension. Must be a power of two, ≥ 2.
- `IW`, $clog2(N): index width.
- `AW`, 2*IW: A/B/C address width (6 for N = 8).

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: start request, sampled only in IDLE.
- `stall` in 1: while high, no new read is issued.
- `rd_en` out 1: A/B read strobe.
- `a_addr` out AW: A address, i*N + k (row-major).
- `b_addr` out AW: B address, k*N + j (row-major).
- `mac_en` out 1: MAC accumulate strobe.
- `mac_clr` out 1: with `mac_en`, load the product instead of adding it.
- `c_we` out 1: C write strobe.
- `c_addr` out AW: C address, i*N + j.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE → RUN when `start`=1.
  - RUN → DRAIN after the issue with i = j = k = N−1 is accepted.
  - DRAIN → DONE once the pipeline is empty.
  - DONE → IDLE unconditionally.
- Iteration counters: k is innermost, then j, then i. Each wraps N−1→0 and carries to the next index. Total issues: N³.
- In RUN with `stall`=0: present the current (i, j, k) on `rd_en`/`a_addr`/`b_addr`, then advance the counters.
- In RUN with `stall`=1: `rd_en`=0, counters hold, and in-flight pipeline stages still advance. A stall inserts a bubble; it never drops or duplicates an issue.
- Pipeline: issue → MAC stage (memory read latency 1) → write stage.
  - `mac_en` = issue valid delayed 1 cycle.
  - `mac_clr` = (k==0) delayed 1 cycle.
  - `c_we` = (k==N−1) delayed 2 cycles, qualified by valid.
  - `c_addr` = i*N + j delayed 2 cycles.
- The C write and the next dot product's `mac_en`+`mac_clr` coincide. The datapath writes the pre-edge accumulator.
- `start` in RUN, DRAIN or DONE is ignored.
- `rst`=0 at any time forces IDLE, clears counters and pipeline, and drives all outputs low on that edge. A run cut short by reset produces no further `c_we` or `done`.
- Address arithmetic is concatenation ({i,k}, {k,j}, {i,j}). No multiplier.

## Timing
- All outputs are registered. Every output resets to 0.
- Let E0 be the edge that samples `start`=1 in IDLE. With no stalls:
  - Issue n (0 … N³−1) is visible after edge E(n).
  - Its `mac_en` is visible after E(n+1).
  - `c_we` for dot product (i, j) is visible after E(n+2), where n is that dot product's k=N−1 issue.
- For N=8: last issue after E511, last `c_we` after E513, `done` after E514 for exactly one cycle.
- `busy`=1 from after E0 until the edge on which `done` rises. `busy` and `done` are never high together.
- Each stall cycle delays everything downstream of it by exactly one cycle.
- `start` may be reasserted the cycle after `done`; the new run's first issue follows that edge.

## Structure
- Package `mat_mul_pkg`: default `N`, the `IW`/`AW` derivations, and the state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module `mm_idx_counter`: nested i/j/k counters with enable, a `last` flag for i=j=k=N−1, and `k_first`/`k_last` flags.
- The top level holds the FSM and the two-stage delay pipeline.

## Test plan
- Reset, then `start` pulse, N=8, no stall → exactly 512 `rd_en`, 512 `mac_en`, 64 `mac_clr`, and 64 `c_we` at `c_addr` 0 … 63 in order. `done` appears after E514.
- Address check: on issue 75 (i=1, j=1, k=3) → `a_addr`=11, `b_addr`=25. That dot product's `c_we` has `c_addr`=9.
- `stall` high for 5 cycles starting mid dot product (k=4) → no duplicate or skipped addresses, and `done` is delayed by exactly 5 cycles (after E519).
- `start` held high through a whole run → exactly one run executes. A second run starts only from IDLE after `done`.
- `rst` low at cycle 200 → next edge has all outputs 0 and state IDLE. No `c_we` or `done` follows until a new `start`.
- With a behavioural MAC and memory model, A = identity and B = random → C equals B.
